// File: rtl/tube_pkg.sv
// Shared types and default sizing for the tube array: FSM states and
// channel/counter/lookback defaults.
package tube_pkg;

    localparam int NCH_DEFAULT      = 8;
    localparam int CW_DEFAULT       = 8;
    localparam int LOOKBACK_DEFAULT = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        READ  = 2'd2
    } state_t;

    // Channel index width, never narrower than one bit.
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tube_channel.sv
// One tube channel: a free-running delay line, a hit latch and a saturating
// counter that measures time from window open to the delayed tube hit.
module tube_channel
    import tube_pkg::*;
#(
    parameter int CW       = CW_DEFAULT,
    parameter int LOOKBACK = LOOKBACK_DEFAULT
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          tube_in,
    input  logic          start,
    input  logic          count_en,
    output logic          hit,
    output logic [CW-1:0] count,
    output logic          done
);

    localparam logic [CW-1:0] COUNT_MAX = '1;

    logic [LOOKBACK-1:0] line;
    logic                delayed;

    // The line keeps shifting through every state; only clr empties it.
    if (LOOKBACK == 1) begin : g_short
        always_ff @(posedge clk or posedge clr) begin
            if (clr) line <= '0;
            else     line <= tube_in;
        end
    end else begin : g_long
        always_ff @(posedge clk or posedge clr) begin
            if (clr) line <= '0;
            else     line <= {line[LOOKBACK-2:0], tube_in};
        end
    end

    assign delayed = line[LOOKBACK-1];

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hit   <= 1'b0;
            count <= '0;
        end else if (start) begin
            hit   <= 1'b0;
            count <= '0;
        end else if (count_en && !hit) begin
            if (delayed)                 hit   <= 1'b1;
            else if (count != COUNT_MAX) count <= count + 1'b1;
        end
    end

    assign done = hit || (count == COUNT_MAX);

endmodule

// File: rtl/tube_array.sv
// Tube array top: gate edge detection, IDLE/COUNT/READ control and the
// ready/valid readout multiplexer over NCH tube channels.
module tube_array
    import tube_pkg::*;
#(
    parameter int NCH      = NCH_DEFAULT,
    parameter int CW       = CW_DEFAULT,
    parameter int LOOKBACK = LOOKBACK_DEFAULT
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic [NCH-1:0]               tube_in,
    input  logic                         gate,
    output logic [CW-1:0]                out_data,
    output logic [chan_width(NCH)-1:0]   out_chan,
    output logic                         out_hit,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    localparam int IW = chan_width(NCH);

    state_t          state, state_next;
    logic [IW-1:0]   rd_idx, rd_idx_next;
    logic            gate_q, armed;
    logic            gate_rise;
    logic            start, count_en;
    logic [NCH-1:0]  hit_v, done_v;
    logic [CW-1:0]   counts [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tube_channel #(
            .CW       (CW),
            .LOOKBACK (LOOKBACK)
        ) u_ch (
            .clk      (clk),
            .clr      (clr),
            .tube_in  (tube_in[i]),
            .start    (start),
            .count_en (count_en),
            .hit      (hit_v[i]),
            .count    (counts[i]),
            .done     (done_v[i])
        );
    end

    // armed stays low for the first cycle after clr so a gate already high
    // at release is not mistaken for a rising edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            gate_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            gate_q <= gate;
            armed  <= 1'b1;
        end
    end

    assign gate_rise = gate && !gate_q && armed;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            rd_idx <= '0;
        end else begin
            state  <= state_next;
            rd_idx <= rd_idx_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next  = state;
        rd_idx_next = rd_idx;
        start       = 1'b0;
        case (state)
            IDLE: begin
                if (gate_rise) begin
                    state_next = COUNT;
                    start      = 1'b1;
                end
            end
            COUNT: begin
                if (!gate || (&done_v)) begin
                    state_next  = READ;
                    rd_idx_next = '0;
                end
            end
            READ: begin
                if (out_ready) begin
                    if (rd_idx == IW'(NCH - 1)) begin
                        state_next  = IDLE;
                        rd_idx_next = '0;
                    end else begin
                        rd_idx_next = rd_idx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign count_en  = (state == COUNT);
    assign out_valid = (state == READ);
    assign busy      = (state != IDLE);
    assign out_chan  = rd_idx;
    assign out_data  = counts[rd_idx];
    assign out_hit   = hit_v[rd_idx];

endmodule

// File: tb/tb_tube_array.sv
// Self-checking bench for tube_array: table-driven windows, hand-written
// stall/reset/re-gate sequences and randomized windows against a model.
module tb_tube_array;
    import tube_pkg::*;

    localparam int NCH = 8;
    localparam int CW  = 8;
    localparam int LB  = 7;
    localparam int SAT = 255;
    localparam int INF = 1 << 30;

    logic            clk = 1'b0;
    logic            clr;
    logic [NCH-1:0]  tube_in;
    logic            gate;
    logic            out_ready;
    logic [CW-1:0]   out_data;
    logic [2:0]      out_chan;
    logic            out_hit;
    logic            out_valid;
    logic            busy;

    always #5 clk = ~clk;

    tube_array #(.NCH(NCH), .CW(CW), .LOOKBACK(LB)) dut (
        .clk       (clk),
        .clr       (clr),
        .tube_in   (tube_in),
        .gate      (gate),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_hit   (out_hit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    typedef struct {
        logic [NCH-1:0] mask;
        int             off;
        int             len;
        logic [NCH-1:0] hit_mask;
        int             hit_data;
        int             other_data;
        int             exit_rel;
    } vec_t;

    vec_t           vecs [6];
    int             n_checks = 0;
    int             n_pass   = 0;
    int             cyc      = 0;
    int             idle_from;
    logic [NCH-1:0] tube_log [int];
    logic           gate_log [int];
    logic [NCH-1:0] plan     [int];
    int             exp_data [NCH];
    bit             exp_hit  [NCH];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Apply inputs for the current cycle, record them, advance one clock.
    task automatic drive(input logic [NCH-1:0] t, input logic g, input logic r);
        tube_in   = t;
        gate      = g;
        out_ready = r;
        tube_log[cyc] = t;
        gate_log[cyc] = g;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " busy"},      busy,      0);
        check({tag, " out_chan"},  out_chan,  0);
        check({tag, " out_data"},  out_data,  0);
        check({tag, " out_hit"},   out_hit,   0);
    endtask

    task automatic fill_expect(input logic [NCH-1:0] hmask, input int hdata, input int odata);
        for (int c = 0; c < NCH; c++) begin
            exp_hit[c]  = hmask[c];
            exp_data[c] = hmask[c] ? hdata : odata;
        end
    endtask

    // Gate rises at rel 0 and stays high for len cycles; plan[rel] is the
    // tube pattern for that cycle. Returns the rel cycle where out_valid is first seen.
    task automatic run_window(input int pre, input int len, output int exit_rel);
        exit_rel = -1;
        for (int rel = -pre; rel < len + 400; rel++) begin
            drive(plan.exists(rel) ? plan[rel] : '0, (rel >= 0) && (rel < len), 1'b0);
            if (out_valid) begin
                exit_rel = rel + 1;
                break;
            end
        end
        if (exit_rel < 0) check("window reached READ", out_valid, 1);
    endtask

    task automatic read_all(input int stall_chan, input int stall_len,
                            input bit rand_ready, input bit gate_in_read);
        int             idx     = 0;
        int             stalled = 0;
        int             guard   = 0;
        logic           r;
        logic [NCH-1:0] t;
        while (idx < NCH && guard < 300) begin
            check($sformatf("rd valid ch%0d", idx), out_valid, 1);
            check($sformatf("rd chan ch%0d", idx),  out_chan,  idx);
            check($sformatf("rd data ch%0d", idx),  out_data,  exp_data[idx]);
            check($sformatf("rd hit ch%0d", idx),   out_hit,   exp_hit[idx]);
            if (idx == stall_chan && stalled < stall_len) begin
                r = 1'b0;
                stalled++;
            end else if (rand_ready) begin
                r = 1'($urandom_range(0, 1));
            end else begin
                r = 1'b1;
            end
            t = rand_ready ? NCH'($urandom) : '0;
            drive(t, gate_in_read && (idx >= 3), r);
            if (r) idx++;
            guard++;
        end
        check("readout completed", idx, NCH);
        check("valid after readout", out_valid, 0);
        check("busy after readout", busy, 0);
        idle_from = cyc;
    endtask

    // Reference model from the recorded history: window rise g, last COUNT
    // cycle e, and per-channel hit/count expressed in closed form.
    task automatic model(output int g, output int e);
        int tlow, d;
        int hs [NCH];
        g = -1;
        e = -1;
        for (int t = idle_from; t < cyc; t++) begin
            if (gate_log.exists(t) && gate_log.exists(t - 1) && gate_log[t] && !gate_log[t - 1]) begin
                g = t;
                break;
            end
        end
        if (g < 0) return;
        tlow = INF;
        for (int t = g + 1; t < cyc; t++) begin
            if (!gate_log[t]) begin
                tlow = t;
                break;
            end
        end
        d = 0;
        for (int c = 0; c < NCH; c++) begin
            hs[c] = INF;
            for (int t = g + 1; t <= g + SAT + 1; t++) begin
                if (tube_log.exists(t - LB) && tube_log[t - LB][c]) begin
                    hs[c] = t;
                    break;
                end
            end
            d = (hs[c] < g + SAT) ? ((hs[c] > d) ? hs[c] : d) : ((g + SAT > d) ? g + SAT : d);
        end
        e = (tlow < d + 1) ? tlow : d + 1;
        for (int c = 0; c < NCH; c++) begin
            exp_hit[c]  = (hs[c] <= e);
            exp_data[c] = ((hs[c] < e + 1) ? hs[c] : e + 1) - g - 1;
            if (exp_data[c] > SAT) exp_data[c] = SAT;
        end
    endtask

    initial begin
        int ex, g, e, off, len;

        //        mask   off  len  hit_mask hit_data other exit
        vecs[0] = '{8'h08,  -2, 300, 8'h08,   4,   255,  257};
        vecs[1] = '{8'h01,  -6,  40, 8'h01,   0,    40,   41};
        vecs[2] = '{8'h01,  -7,  40, 8'h00,   0,    40,   41};
        vecs[3] = '{8'h80,   0,  40, 8'h80,   6,    40,   41};
        vecs[4] = '{8'h20,  33,  40, 8'h20,  39,    40,   41};
        vecs[5] = '{8'h20,  34,  40, 8'h00,   0,    40,   41};

        clr = 1'b1; tube_in = '0; gate = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        clr = 1'b0;
        tube_log.delete();
        gate_log.delete();
        idle_from = cyc;

        for (int i = 0; i < 6; i++) begin
            plan.delete();
            plan[vecs[i].off] = vecs[i].mask;
            run_window(10, vecs[i].len, ex);
            check($sformatf("vec%0d exit cycle", i), ex, vecs[i].exit_rel);
            fill_expect(vecs[i].hit_mask, vecs[i].hit_data, vecs[i].other_data);
            read_all(-1, 0, 1'b0, 1'b0);
        end

        // Every channel hit early: early exit, then a 5-cycle stall on channel 2.
        plan.delete();
        for (int i = 0; i < NCH; i++) plan[i] = NCH'(1) << i;
        run_window(10, 100, ex);
        check("all-hit early exit", ex, 16);
        for (int c = 0; c < NCH; c++) begin
            exp_hit[c]  = 1'b1;
            exp_data[c] = 6 + c;
        end
        read_all(2, 5, 1'b0, 1'b0);

        // Gate edge during READ is ignored; a fresh edge from IDLE opens a window.
        plan.delete();
        run_window(10, 20, ex);
        check("pre-regate exit", ex, 21);
        fill_expect('0, 0, 20);
        read_all(-1, 0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive('0, 1'b1, 1'b0);
            check($sformatf("READ gate edge ignored %0d", k), busy, 0);
        end
        plan.delete();
        run_window(10, 12, ex);
        check("regate exit", ex, 13);
        fill_expect('0, 0, 12);
        read_all(-1, 0, 1'b0, 1'b0);

        // clr in the tenth COUNT cycle, gate held high through release.
        plan.delete();
        plan[5] = 8'h20;
        for (int rel = -10; rel < 10; rel++)
            drive(plan.exists(rel) ? plan[rel] : '0, rel >= 0, 1'b0);
        check("busy before clr", busy, 1);
        clr = 1'b1;
        #1;
        check_all_zero("clr async");
        for (int k = 0; k < 3; k++) begin
            drive('0, 1'b1, 1'b1);
            check_all_zero($sformatf("clr held %0d", k));
        end
        clr = 1'b0;
        tube_log.delete();
        gate_log.delete();
        idle_from = cyc;
        for (int k = 0; k < 20; k++) begin
            drive('0, 1'b1, 1'b1);
            check($sformatf("no window after clr %0d", k), busy, 0);
        end
        plan.delete();
        run_window(10, 30, ex);
        check("post-clr exit", ex, 31);
        fill_expect('0, 0, 30);
        read_all(-1, 0, 1'b0, 1'b0);

        // Randomized windows against the model.
        for (int w = 0; w < 10; w++) begin
            plan.delete();
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 2) != 0) begin
                    off = int'($urandom_range(0, 45)) - 8;
                    if (!plan.exists(off)) plan[off] = '0;
                    plan[off] = plan[off] | (NCH'(1) << c);
                end
            end
            len = (w == 4) ? 300 : int'($urandom_range(3, 60));
            run_window(10, len, ex);
            model(g, e);
            check($sformatf("rand%0d exit cycle", w), ex, (g < 0) ? -1 : e + 1 - g);
            read_all(-1, 0, 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tube_array.md
TUBE_ARRAY -- requirements
Module: tube_array

Interface
REQ-001 The module SHALL have parameter NCH, default 8, number of tube channels (1..64).
REQ-002 The module SHALL have parameter CW, default 8, counter width in bits (4..16).
REQ-003 The module SHALL have parameter LOOKBACK, default 7, tube-input delay in clock cycles (1..32).
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port clr, input, 1 bit, asynchronous active-high reset.
REQ-006 The module SHALL have port tube_in, input, NCH bits, raw tube discriminator levels, one bit per channel.
REQ-007 The module SHALL have port gate, input, 1 bit, scintillator coincidence gate; a rising edge opens a measurement window.
REQ-008 The module SHALL have port out_data, output, CW bits, count of the channel being read out.
REQ-009 The module SHALL have port out_chan, output, clog2(NCH) bits (minimum 1), index of the channel being read out.
REQ-010 The module SHALL have port out_hit, output, 1 bit, set when the channel latched a hit; clear when it saturated.
REQ-011 The module SHALL have port out_valid, output, 1 bit, readout word valid.
REQ-012 The module SHALL have port out_ready, input, 1 bit, downstream FIFO accepts the word.
REQ-013 The module SHALL have port busy, output, 1 bit, high in the COUNT and READ states.

Function
REQ-014 Each channel SHALL delay tube_in by exactly LOOKBACK cycles through a shift line that runs continuously in every state and is never cleared by a gate.
REQ-015 The state machine SHALL have the states IDLE, COUNT and READ.
REQ-016 In IDLE, a gate rising edge (gate=1 this cycle, 0 the previous cycle) SHALL move the machine to COUNT on the next edge, clearing all counters and hit latches on that same edge.
REQ-017 In COUNT, each channel counter SHALL increment by 1 per cycle while its hit latch is 0 and its count is below 2^CW-1.
REQ-018 A channel counter SHALL saturate at 2^CW-1 and never wrap.
REQ-019 In COUNT, a delayed tube bit of 1 SHALL set the channel hit latch; in that cycle the counter SHALL NOT increment, and it holds thereafter.
REQ-020 Once set, a hit latch SHALL remain set until the next window opens, whatever later tube activity occurs.
REQ-021 COUNT SHALL exit to READ on the edge after gate is sampled low or after every channel is latched or saturated, whichever comes first.
REQ-022 In READ, channels SHALL be presented in index order 0..NCH-1, with out_valid=1 and out_data/out_chan/out_hit held stable until out_ready=1.
REQ-023 A READ handshake (out_valid and out_ready both 1) SHALL advance to the next channel on the following cycle with no bubble; the handshake on channel NCH-1 SHALL return the machine to IDLE with out_valid=0.
REQ-024 Gate edges during COUNT or READ SHALL be ignored; a new window requires IDLE and a fresh rising edge.
REQ-025 out_valid SHALL be 0 outside READ; busy SHALL be 1 exactly in COUNT and READ.

Reset
REQ-026 clr=1 SHALL asynchronously force state IDLE, all counters 0, all hit latches 0, all delay lines 0, out_valid 0, busy 0, out_chan 0 and the gate edge register 0.
REQ-027 clr asserted mid-COUNT or mid-READ SHALL abandon the window, and no partial readout SHALL follow release.
REQ-028 After clr release, a gate already high SHALL NOT count as a rising edge.

Structure
REQ-029 Package tube_pkg SHALL hold the state enumeration and the default values of NCH, CW and LOOKBACK.
REQ-030 Sub-module tube_channel SHALL contain the delay line, hit latch and saturating counter of one channel, instantiated NCH times; tube_array SHALL own the state machine and the readout multiplexer.

Verification
REQ-031 With NCH=8, CW=8, LOOKBACK=7: pulse tube_in[3] high 2 cycles before the gate rises and hold the gate 300 cycles -> channel 3 reads out_hit=1 with data 4, and the other channels read out_hit=0 with data 255.
REQ-032 With tube_in[0] high in the same cycle the latch would otherwise count -> the counter freezes without incrementing; exact expected count N is checked against a cycle-accurate model.
REQ-033 With all channels hit within 20 cycles -> early exit to READ before gate falls, and 8 words follow in order 0..7.
REQ-034 Hold out_ready=0 for 5 cycles on channel 2 -> out_data/out_chan/out_hit stay stable; release out_ready -> words 3..7 stream back-to-back, then busy=0.
REQ-035 Assert clr in cycle 10 of COUNT, then re-gate -> all outputs are 0 during clr, there is no stale readout, and the new window counts from 0.
REQ-036 Apply a second gate edge during READ -> it is ignored, and a gate edge after IDLE opens a new window.
